// File: rtl/picorv32_pcpi_gf_inv.sv
// rtl/picorv32_pcpi_gf_inv.sv - PCPI GF(2^m) inverse unit (binary extended Euclid), one step per clock
module picorv32_pcpi_gf_inv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);
  localparam int W = DATA_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, INIT, RUN, CFG, DONE, HOLD} state_t;
  state_t state, state_next;

  logic [5:0]            cfg_m, new_m;
  logic [DATA_WIDTH-1:0] cfg_poly, res;
  logic [W-1:0]          u, v, g1, g2, nu, nv, ng1, ng2;
  logic [W-1:0]          f_full, a_mask, new_mask;
  logic                  is_op, dec_inv, dec_cfg, cfg_ok, term;
  logic                  unused_bits;

  function automatic logic [5:0] deg(input logic [W-1:0] x);
    logic [5:0] d;
    d = '0;
    for (int i = 0; i < W; i++) if (x[i]) d = 6'(i);
    return d;
  endfunction

  assign is_op   = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000100);
  assign dec_inv = pcpi_valid && is_op && (pcpi_insn[14:12] == 3'd3);
  assign dec_cfg = pcpi_valid && is_op && (pcpi_insn[14:12] == 3'd5);

  assign f_full   = (W'(1) << cfg_m) | W'(cfg_poly);
  assign a_mask   = (W'(1) << cfg_m) - W'(1);
  assign new_m    = pcpi_rs1[5:0];
  assign new_mask = (W'(1) << new_m) - W'(1);
  assign cfg_ok   = (new_m >= 6'd2) && (new_m <= 6'(DATA_WIDTH));
  assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], new_mask[W-1]};

  always_comb begin
    nu = u; nv = v; ng1 = g1; ng2 = g2;
    if (!u[0]) begin
      nu  = u >> 1;
      ng1 = g1[0] ? ((g1 ^ f_full) >> 1) : (g1 >> 1);
    end else if (!v[0]) begin
      nv  = v >> 1;
      ng2 = g2[0] ? ((g2 ^ f_full) >> 1) : (g2 >> 1);
    end else if (deg(u) > deg(v)) begin
      nu  = u ^ v;
      ng1 = g1 ^ g2;
    end else begin
      nv  = v ^ u;
      ng2 = g2 ^ g1;
    end
  end

  // Checking the post-step values is the same as checking before the next step
  assign term = (nu == W'(1)) || (nv == W'(1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dec_inv)      state_next = INIT;
        else if (dec_cfg) state_next = CFG;
      end
      // a==0 and a==1 need no steps; the result is a itself
      INIT: begin
        if (!pcpi_valid)         state_next = IDLE;
        else if (u <= W'(1))     state_next = DONE;
        else                     state_next = RUN;
      end
      RUN: begin
        if (!pcpi_valid) state_next = IDLE;
        else if (term)   state_next = DONE;
      end
      CFG, DONE: state_next = HOLD;
      HOLD:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cfg_m    <= 6'd8;
      cfg_poly <= DATA_WIDTH'(32'h1B);
      u        <= '0;
      v        <= '0;
      g1       <= '0;
      g2       <= '0;
      res      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (dec_inv) begin
            u  <= W'(pcpi_rs1) & a_mask;
            v  <= f_full;
            g1 <= W'(1);
            g2 <= '0;
          end
          if (dec_cfg && cfg_ok) begin
            cfg_m    <= new_m;
            cfg_poly <= pcpi_rs2[DATA_WIDTH-1:0] & new_mask[DATA_WIDTH-1:0];
          end
        end
        INIT: res <= u[DATA_WIDTH-1:0];
        RUN: begin
          u   <= nu;
          v   <= nv;
          g1  <= ng1;
          g2  <= ng2;
          res <= (nu == W'(1)) ? ng1[DATA_WIDTH-1:0] : ng2[DATA_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  // rd is forced to zero outside DONE so it can be OR-combined with the sibling unit
  assign pcpi_ready = (state == CFG) || (state == DONE);
  assign pcpi_wr    = (state == DONE);
  assign pcpi_wait  = (state == INIT) || (state == RUN);
  assign pcpi_rd    = (state == DONE) ? 32'(res) : 32'd0;

endmodule

// File: tb/tb_picorv32_pcpi_gf_inv.sv
// tb/tb_picorv32_pcpi_gf_inv.sv - randomized self-checking bench for picorv32_pcpi_gf_inv
module tb_picorv32_pcpi_gf_inv;
  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] OP = 7'b0110011;
  localparam logic [6:0] F7 = 7'b0000100;

  picorv32_pcpi_gf_inv #(.DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 5'd3, 5'd2, f3, 5'd1, op};
  endfunction

  // Carry-less product of a and b reduced modulo x^m + poly
  function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b, input int m,
                                         input logic [31:0] poly);
    logic [63:0] p, f;
    p = '0;
    f = (64'd1 << m) | {32'd0, poly};
    for (int i = 0; i < m; i++) if (b[i]) p = p ^ ({32'd0, a} << i);
    for (int i = 2 * m - 2; i >= m; i--) if (p[i]) p = p ^ (f << (i - m));
    return p[31:0];
  endfunction

  // Exhaustive search for the inverse in small fields
  function automatic logic [31:0] ref_inv(input logic [31:0] a, input int m, input logic [31:0] poly);
    if (a == 0) return 32'd0;
    for (int r = 1; r < (1 << m); r++)
      if (gf_mul(a, 32'(r), m, poly) == 32'd1) return 32'(r);
    return 32'd0;
  endfunction

  // Issues one instruction, holds valid until ready, then drops valid and samples one more cycle
  task automatic run_insn(input logic [31:0] insn, input logic [31:0] a1, input logic [31:0] a2,
                          output logic [31:0] rd, output logic wr, output int lat,
                          output bit wait_ok, output bit tail_ok);
    @(posedge clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = insn; pcpi_rs1 = a1; pcpi_rs2 = a2;
    @(posedge clk); #1;
    pcpi_rs1 = $urandom; pcpi_rs2 = $urandom;
    lat = -1; wait_ok = 1'b1; tail_ok = 1'b1; rd = '0; wr = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (pcpi_ready) begin
        rd = pcpi_rd; wr = pcpi_wr; lat = k;
        if (pcpi_wait) wait_ok = 1'b0;
        break;
      end
      if (!pcpi_wait || pcpi_rd != 0 || pcpi_wr) wait_ok = 1'b0;
      @(posedge clk); #1;
    end
    pcpi_valid = 1'b0;
    @(posedge clk); #1;
    if (pcpi_ready || pcpi_rd != 0 || pcpi_wr || pcpi_wait) tail_ok = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; pcpi_valid = 1'b1; pcpi_insn = mk(F7, 3'd3, OP); pcpi_rs1 = 32'h53; pcpi_rs2 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({pcpi_ready, pcpi_wr, pcpi_wait} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl: got %b want 000", {pcpi_ready, pcpi_wr, pcpi_wait}); end
    checks++; if (pcpi_rd !== 32'd0) begin errors++;
      $display("FAIL reset_rd: got %h want 00000000", pcpi_rd); end
    pcpi_valid = 1'b0; resetn = 1'b1;
  endtask

  task automatic test_default_inv();
    logic [31:0] rd; logic wr; int lat; bit wok, tok;
    run_insn(mk(F7, 3'd3, OP), 32'h53, $urandom, rd, wr, lat, wok, tok);
    checks++; if (rd !== ref_inv(32'h53, 8, 32'h1B) || rd !== 32'hCA) begin errors++;
      $display("FAIL inv_53_rd: got %h want ca", rd); end
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL inv_53_wr: got %b want 1", wr); end
    checks++; if (!wok || lat < 3) begin errors++;
      $display("FAIL inv_53_wait: wait_ok=%0d lat=%0d want wait continuous, lat>=3", wok, lat); end
    checks++; if (!tok) begin errors++; $display("FAIL inv_53_pulse: ready/rd not cleared after one cycle"); end
  endtask

  task automatic test_boundary();
    logic [31:0] rd, a; logic wr; int lat; bit wok, tok;
    run_insn(mk(F7, 3'd3, OP), 32'h1, 0, rd, wr, lat, wok, tok);
    checks++; if (rd !== 32'h1 || lat != 2 || wr !== 1'b1) begin errors++;
      $display("FAIL inv_one: got rd=%h lat=%0d wr=%b want rd=1 lat=2 wr=1", rd, lat, wr); end
    run_insn(mk(F7, 3'd3, OP), 32'h0, 0, rd, wr, lat, wok, tok);
    checks++; if (rd !== 32'h0 || lat != 2 || wr !== 1'b1) begin errors++;
      $display("FAIL inv_zero: got rd=%h lat=%0d wr=%b want rd=0 lat=2 wr=1", rd, lat, wr); end
    run_insn(mk(F7, 3'd3, OP), 32'h153, 0, rd, wr, lat, wok, tok);
    checks++; if (rd !== 32'hCA) begin errors++; $display("FAIL inv_masked: got %h want ca", rd); end
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      run_insn(mk(F7, 3'd3, OP), a, $urandom, rd, wr, lat, wok, tok);
      checks++; if (rd !== ref_inv(a & 32'hFF, 8, 32'h1B) || !wok || !tok) begin errors++;
        $display("FAIL inv_rand8: a=%h got %h want %h wait_ok=%0d tail_ok=%0d",
                 a, rd, ref_inv(a & 32'hFF, 8, 32'h1B), wok, tok); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seen;
    @(posedge clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = mk(F7, 3'd3, OP); pcpi_rs1 = 32'h1; pcpi_rs2 = 0;
    seen = '0;
    for (int k = 0; k <= 7; k++) begin
      @(posedge clk); #1;
      if (pcpi_ready) seen[k+1] = 1'b1;
    end
    pcpi_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (seen !== 16'h0044) begin errors++;
      $display("FAIL back_to_back_ready_cycles: got %h want 0044", seen); end
  endtask

  task automatic test_config();
    logic [31:0] rd; logic wr; int lat; bit wok, tok;
    run_insn(mk(F7, 3'd5, OP), 32'd4, 32'h3, rd, wr, lat, wok, tok);
    checks++; if (lat != 1 || wr !== 1'b0 || !wok || rd !== 0) begin errors++;
      $display("FAIL cfg4: got lat=%0d wr=%b wait_ok=%0d rd=%h want lat=1 wr=0 wait_ok=1 rd=0", lat, wr, wok, rd); end
    run_insn(mk(F7, 3'd3, OP), 32'h2, 0, rd, wr, lat, wok, tok);
    checks++; if (rd !== ref_inv(32'h2, 4, 32'h3)) begin errors++;
      $display("FAIL inv_m4: got %h want %h", rd, ref_inv(32'h2, 4, 32'h3)); end
    run_insn(mk(F7, 3'd5, OP), 32'd40, 32'h1F, rd, wr, lat, wok, tok);
    checks++; if (lat != 1 || wr !== 1'b0) begin errors++;
      $display("FAIL cfg40: got lat=%0d wr=%b want lat=1 wr=0", lat, wr); end
    run_insn(mk(F7, 3'd3, OP), 32'h2, 0, rd, wr, lat, wok, tok);
    checks++; if (rd !== 32'h9) begin errors++; $display("FAIL inv_m4_after_bad_cfg: got %h want 9", rd); end
    run_insn(mk(F7, 3'd5, OP), 32'd4, 32'hFFFF_FFF3, rd, wr, lat, wok, tok);
    for (int a = 1; a < 16; a++) begin
      run_insn(mk(F7, 3'd3, OP), 32'(a) | 32'hABC0, 0, rd, wr, lat, wok, tok);
      checks++; if (rd !== ref_inv(32'(a), 4, 32'h3)) begin errors++;
        $display("FAIL inv_m4_all: a=%0d got %h want %h", a, rd, ref_inv(32'(a), 4, 32'h3)); end
    end
  endtask

  task automatic test_full_width();
    logic [31:0] rd, a; logic wr; int lat; bit wok, tok;
    run_insn(mk(F7, 3'd5, OP), 32'd32, 32'h8D, rd, wr, lat, wok, tok);
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      if (a == 0) a = 32'h1;
      run_insn(mk(F7, 3'd3, OP), a, $urandom, rd, wr, lat, wok, tok);
      checks++; if (gf_mul(a, rd, 32, 32'h8D) !== 32'h1 || wr !== 1'b1) begin errors++;
        $display("FAIL inv_m32: a=%h got %h product %h want product 1", a, rd, gf_mul(a, rd, 32, 32'h8D)); end
      checks++; if (lat < 2 || lat - 2 > 128 || !wok) begin errors++;
        $display("FAIL inv_m32_steps: a=%h got N=%0d wait_ok=%0d want N<=128", a, lat - 2, wok); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic wr; int lat; bit wok, tok; bit saw_ready;
    @(posedge clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = mk(F7, 3'd3, OP); pcpi_rs1 = 32'h1234_5678; pcpi_rs2 = 0;
    repeat (3) @(posedge clk);
    #1;
    pcpi_valid = 1'b0;
    saw_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (pcpi_wait !== 1'b0) begin errors++; $display("FAIL abort_wait: got %b want 0", pcpi_wait); end
    for (int k = 0; k < 8; k++) begin
      if (pcpi_ready) saw_ready = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_ready) begin errors++; $display("FAIL abort_ready: got 1 want 0"); end
    run_insn(mk(F7, 3'd3, OP), 32'h1, 0, rd, wr, lat, wok, tok);
    checks++; if (rd !== 32'h1 || lat != 2) begin errors++;
      $display("FAIL abort_recover: got rd=%h lat=%0d want rd=1 lat=2", rd, lat); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd; logic wr; int lat; bit wok, tok;
    @(posedge clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = mk(F7, 3'd3, OP); pcpi_rs1 = 32'h1234_5678; pcpi_rs2 = 0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (pcpi_wait !== 1'b1) begin errors++; $display("FAIL midrun_wait: got %b want 1", pcpi_wait); end
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++; if ({pcpi_ready, pcpi_wr, pcpi_wait} !== 3'b000 || pcpi_rd !== 32'd0) begin errors++;
      $display("FAIL midrun_reset_outputs: got ctrl=%b rd=%h want 000 and 0",
               {pcpi_ready, pcpi_wr, pcpi_wait}, pcpi_rd); end
    pcpi_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    run_insn(mk(F7, 3'd3, OP), 32'h153, 0, rd, wr, lat, wok, tok);
    checks++; if (rd !== 32'hCA) begin errors++; $display("FAIL midrun_cfg_restored: got %h want ca", rd); end
    run_insn(mk(F7, 3'd3, OP), 32'h53, 0, rd, wr, lat, wok, tok);
    checks++; if (rd !== 32'hCA || wr !== 1'b1) begin errors++;
      $display("FAIL midrun_inv_53: got rd=%h wr=%b want ca 1", rd, wr); end
  endtask

  task automatic test_nonmatch();
    logic [31:0] insns [6];
    bit bad;
    insns[0] = mk(F7, 3'd0, OP);
    insns[1] = mk(F7, 3'd1, OP);
    insns[2] = mk(F7, 3'd2, OP);
    insns[3] = mk(F7, 3'd4, OP);
    insns[4] = 32'h00A1_2223;
    insns[5] = mk(7'b0000001, 3'd3, OP);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pcpi_valid = 1'b1; pcpi_insn = insns[i]; pcpi_rs1 = 32'h53; pcpi_rs2 = $urandom;
      bad = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (pcpi_ready || pcpi_wr || pcpi_wait || pcpi_rd != 0) bad = 1'b1;
      end
      pcpi_valid = 1'b0;
      checks++; if (bad) begin errors++; $display("FAIL nonmatch_quiet: insn=%h produced output, want none", insns[i]); end
    end
  endtask

  initial begin
    resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    test_reset();
    test_default_inv();
    test_boundary();
    test_back_to_back();
    test_config();
    test_full_width();
    test_abort();
    test_reset_mid_run();
    test_nonmatch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
